// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per clock through a
// single shared adder, with valid/ready handshakes on operands and product.
module seq_shift_add_multiplier #(
  parameter int M_WIDTH = 3,
  parameter int Q_WIDTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [M_WIDTH-1:0]         m,
  input  logic [Q_WIDTH-1:0]         q,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       abort,
  output logic [M_WIDTH+Q_WIDTH-1:0] product,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // CALC  | one shift-add step per edge, Q_WIDTH edges total
  // DONE  | product presented until out_ready

  localparam int AW = M_WIDTH + Q_WIDTH;
  localparam int CW = $clog2(Q_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, nextState;

  logic [M_WIDTH-1:0] mReg;
  logic [Q_WIDTH-1:0] qReg;
  logic [AW-1:0]      acc;
  logic [CW-1:0]      count;
  logic [M_WIDTH-1:0] addend;
  logic [M_WIDTH:0]   sum;
  logic [AW:0]        shifted;
  logic [AW-1:0]      accNext;
  logic               lastStep;

  // Carry-out of the upper-half add becomes the new MSB after the right shift.
  always_comb begin
    addend   = qReg[0] ? mReg : '0;
    sum      = {1'b0, acc[AW-1:Q_WIDTH]} + {1'b0, addend};
    shifted  = {sum, acc[Q_WIDTH-1:0]};
    accNext  = shifted[AW:1];
    lastStep = (count == CW'(Q_WIDTH - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (in_valid) nextState = CALC;
      CALC: begin
        if (abort)         nextState = IDLE;
        else if (lastStep) nextState = DONE;
      end
      DONE: if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == CALC);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mReg    <= '0;
      qReg    <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mReg  <= m;
            qReg  <= q;
            acc   <= '0;
            count <= '0;
          end
        end
        CALC: begin
          if (!abort) begin
            acc   <= accNext;
            qReg  <= qReg >> 1;
            count <= count + 1'b1;
            if (lastStep) product <= accNext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed self-checking bench for seq_shift_add_multiplier: default 3x2 instance plus an 8x8 instance.
module tb_seq_shift_add_multiplier;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  m;
  logic [1:0]  q;
  logic        inValid, inReady, abort, outValid, outReady, busy;
  logic [4:0]  product;

  logic [7:0]  m8, q8;
  logic        inValid8, inReady8, abort8, outValid8, outReady8, busy8;
  logic [15:0] product8;

  int checks = 0;
  int failures = 0;
  int lat;

  always #5 clock = ~clock;

  seq_shift_add_multiplier dut (
    .clock(clock), .reset(reset), .m(m), .q(q), .in_valid(inValid), .in_ready(inReady),
    .abort(abort), .product(product), .out_valid(outValid), .out_ready(outReady), .busy(busy)
  );

  seq_shift_add_multiplier #(.M_WIDTH(8), .Q_WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .m(m8), .q(q8), .in_valid(inValid8), .in_ready(inReady8),
    .abort(abort8), .product(product8), .out_valid(outValid8), .out_ready(outReady8), .busy(busy8)
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Accept one operand pair on the default instance and wait for its product.
  task automatic runOp(input logic [2:0] mv, input logic [1:0] qv, input logic [4:0] expProd,
                       input bit withAbort);
    checkEq("readyBeforeAccept", inReady, 1);
    m = mv; q = qv; inValid = 1'b1; abort = withAbort;
    step();
    inValid = 1'b0; abort = 1'b0;
    checkEq("busyAfterAccept", busy, 1);
    lat = 0;
    while (!outValid && lat < 20) begin
      step();
      lat++;
    end
    checkEq("outValidSeen", outValid, 1);
    checkEq("latency", lat, 2);
    checkEq("product", product, expProd);
    if (outReady) begin
      step();
      checkEq("idleAfterDone", inReady, 1);
      checkEq("outValidCleared", outValid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    m = '0; q = '0; inValid = 0; abort = 0; outReady = 1;
    m8 = '0; q8 = '0; inValid8 = 0; abort8 = 0; outReady8 = 1;
    repeat (2) @(posedge clock);
    #3;
    checkEq("resetInReady", inReady, 1);
    checkEq("resetOutValid", outValid, 0);
    checkEq("resetBusy", busy, 0);
    checkEq("resetProduct", product, 0);
    reset = 1'b0;
    step();

    // basic 3*3
    runOp(3'd3, 2'd3, 5'd9, 1'b0);

    // exhaustive 3x2
    for (int mi = 0; mi < 8; mi++)
      for (int qi = 0; qi < 4; qi++)
        runOp(3'(mi), 2'(qi), 5'(mi * qi), 1'b0);

    // abort coinciding with accept is ignored
    runOp(3'd4, 2'd3, 5'd12, 1'b1);

    // stall with out_ready low; new operands ignored in DONE
    outReady = 1'b0;
    runOp(3'd5, 2'd2, 5'd10, 1'b0);
    m = 3'd1; q = 2'd1; inValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checkEq("stallOutValid", outValid, 1);
      checkEq("stallProduct", product, 10);
      checkEq("stallInReady", inReady, 0);
    end
    outReady = 1'b1;
    step();
    checkEq("releaseIdle", inReady, 1);
    inValid = 1'b0;
    runOp(3'd1, 2'd1, 5'd1, 1'b0);

    // operands changed during CALC do not disturb the op in flight
    m = 3'd6; q = 2'd1; inValid = 1'b1;
    step();
    m = 3'd7; q = 2'd3;
    step();
    inValid = 1'b0;
    step();
    checkEq("inflightOutValid", outValid, 1);
    checkEq("inflightProduct", product, 6);
    step();
    checkEq("inflightIdle", inReady, 1);

    // async reset mid-CALC
    m = 3'd7; q = 2'd3; inValid = 1'b1;
    step();
    inValid = 1'b0;
    #3 reset = 1'b1;
    #1;
    checkEq("asyncProduct", product, 0);
    checkEq("asyncOutValid", outValid, 0);
    checkEq("asyncInReady", inReady, 1);
    checkEq("asyncBusy", busy, 0);
    #2 reset = 1'b0;
    step();
    runOp(3'd2, 2'd3, 5'd6, 1'b0);

    // abort mid-CALC
    m = 3'd5; q = 2'd3; inValid = 1'b1;
    step();
    inValid = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    checkEq("abortInReady", inReady, 1);
    checkEq("abortOutValid", outValid, 0);
    checkEq("abortProduct", product, 6);
    step();
    checkEq("abortNoValid", outValid, 0);
    runOp(3'd3, 2'd1, 5'd3, 1'b0);

    // 8x8: abort mid-op, then 255*255
    m8 = 8'd255; q8 = 8'd255; inValid8 = 1'b1;
    step();
    inValid8 = 1'b0;
    repeat (3) step();
    abort8 = 1'b1;
    step();
    abort8 = 1'b0;
    checkEq("abort8InReady", inReady8, 1);
    checkEq("abort8OutValid", outValid8, 0);
    checkEq("abort8Product", product8, 0);
    inValid8 = 1'b1;
    step();
    inValid8 = 1'b0;
    lat = 0;
    while (!outValid8 && lat < 40) begin
      step();
      lat++;
    end
    checkEq("outValid8Seen", outValid8, 1);
    checkEq("latency8", lat, 8);
    checkEq("product8", product8, 65025);
    step();
    checkEq("idle8", inReady8, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
- Parametrised sequential unsigned multiplier; generalises the fixed 2-bit x 3-bit combinational array to an M_WIDTH x Q_WIDTH operation.
- Uses one shared adder per cycle (shift-and-add, one multiplier bit per clock) instead of a full array of adder cells.
- Sits between operand producers and result consumers on valid/ready handshakes, for area-constrained datapaths where a full array is too large.

Parameters:
- M_WIDTH, 3, multiplicand width in bits (>=1).
- Q_WIDTH, 2, multiplier width in bits (>=1); also the number of compute cycles.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- m  input  M_WIDTH  multiplicand; sampled on the accepting edge.
- q  input  Q_WIDTH  multiplier; sampled on the accepting edge.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- abort  input  1  synchronous cancel of an operation in progress.
- product  output  M_WIDTH+Q_WIDTH  unsigned m*q; stable while out_valid=1.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- busy  output  1  high in CALC.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0. Internal accumulator, operand registers and counter are all cleared. No partial result survives.
- FSM states IDLE, CALC, DONE. Outputs are registered, or decoded from state only. There are no combinational paths from input to output.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch m and q, clear the accumulator, set count=0, and go to CALC.
  - product holds its last value.
- CALC:
  - in_ready=0, busy=1.
  - Each edge: if q_reg[0]=1, add m_reg into the upper M_WIDTH bits of the accumulator. The adder carry-out becomes the new MSB. Then shift the accumulator right 1, shift q_reg right 1, and increment count.
  - There is no early termination. Exactly Q_WIDTH CALC edges run, whatever the operand values.
  - On the edge where count reaches Q_WIDTH, load product from the accumulator, set out_valid=1, and go to DONE.
- Latency: out_valid rises Q_WIDTH rising edges after the accepting edge. Minimum spacing between accepts is Q_WIDTH+2 cycles.
- DONE:
  - out_valid=1, in_ready=0, product held.
  - On an edge with out_ready=1, clear out_valid and go to IDLE.
  - in_valid asserted in DONE is ignored. A new accept occurs no earlier than the first IDLE cycle.
- in_valid in CALC or DONE: ignored, and the operand registers do not change. A producer must hold in_valid until in_ready=1.
- abort=1 in CALC: go to IDLE on that edge. out_valid stays 0 and product keeps its previous value.
- abort in IDLE or DONE: no effect. An abort in the same cycle as an accept is ignored, so the accept proceeds.
- Arithmetic:
  - Product width M_WIDTH+Q_WIDTH, so overflow cannot occur.
  - Zero operands produce 0 with the same latency.
  - Max case: (2^M_WIDTH-1)*(2^Q_WIDTH-1) is exact.
- Count register width: clog2(Q_WIDTH+1). No wrap-around is possible.
- Q_WIDTH=1: a single CALC cycle. Must be legal.

Test Plan:
- Defaults, m=3, q=3, in_valid pulse, out_ready=1 -> out_valid exactly 2 edges after accept, product=9. Back in IDLE one cycle later with in_ready=1.
- Defaults, exhaustive: all 32 (m,q) pairs back-to-back -> product=m*q each time; max 7*3=21. Zero cases give 0 with unchanged latency.
- Stall: out_ready=0 for 5 cycles after out_valid with m=5, q=2 -> product=10 held, out_valid stays 1, in_ready=0. New in_valid (m=1, q=1) ignored until release; afterwards product=1.
- in_valid toggled with different operands during CALC (m=6, q=1 in flight) -> result is 6; the in-flight operands are unaffected.
- Async reset asserted mid-CALC, not aligned to clock -> product=0, out_valid=0, in_ready=1 immediately. The next operation (m=2, q=3) gives 6.
- Abort mid-CALC, then new op; also M_WIDTH=8, Q_WIDTH=8 with 255*255 -> no out_valid for the aborted op. 8x8 gives product=65025, out_valid 8 edges after accept.
